// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Purpose:
//   Multiplexes four active-low seven-segment patterns onto one shared segment
//   bus and a 4-bit active-low anode bus. The controller runs from a single
//   clock, and all timing comes from internal counters.
//
//   Each digit owns one slot of SCAN_DIV cycles. A slot has three parts:
//     GUARD : the first GUARD cycles. All anodes are off, which suppresses
//             ghosting while the segment bus changes.
//     ON    : the next on_len cycles. The slot's anode is driven and the
//             segments follow the selected digit input live.
//     DIM   : the rest of the slot. All anodes are off.
//
//   on_len = ((SCAN_DIV-GUARD)*(bright+1))>>3. bright is captured at the start
//   of each slot, so a change to it only affects the next slot.
//
//   While blinking is enabled, a digit whose mask bit is set is blanked in the
//   hidden half of the blink period. Its anode is still driven, but its
//   segments are forced off.
//
// Ports:
//   clk          system clock; all logic uses the rising edge
//   rst          synchronous, active-high reset
//   dig0..dig3   active-low segment patterns (dig0 = rightmost)
//   blink_en     global blink enable
//   blink_mask   bit i set = digit i blinks
//   bright       brightness 0..7 (ON duty = (bright+1)/8 of post-guard time)
//   seg          registered active-low segment bus
//   an           registered active-low anode select (never more than one low)
//   frame_start  registered one-cycle pulse at the start of each 4-digit frame
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   GUARD      blanked cycles at the start of each slot (< SCAN_DIV)
//   BLINK_DIV  clk cycles per blink half-period
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,
   parameter int GUARD     = 1000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dig0,
   input  logic [7:0] dig1,
   input  logic [7:0] dig2,
   input  logic [7:0] dig3,
   input  logic       blink_en,
   input  logic [3:0] blink_mask,
   input  logic [2:0] bright,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic       frame_start
);

   // Width of the slot counter.
   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   // on_len can reach SCAN_DIV-GUARD, which equals SCAN_DIV when GUARD=0.
   localparam int LEN_W  = $clog2(SCAN_DIV + 1);
   // The span times (bright+1) needs three more bits than on_len before >>3.
   localparam int PROD_W = LEN_W + 3;
   localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(BLINK_DIV - 1);
   localparam logic [PROD_W-1:0] SPAN       = PROD_W'(SCAN_DIV - GUARD);
   localparam logic [LEN_W:0]    GUARD_W    = (LEN_W + 1)'(GUARD);

   // Which part of the slot the current slot_cnt falls in.
   typedef enum logic [1:0] {
      PH_GUARD = 2'd0,
      PH_ON    = 2'd1,
      PH_DIM   = 2'd2
   } phase_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] slot_cnt_q,    slot_cnt_d;
   logic [1:0]       idx_q,         idx_d;
   logic [BLK_W-1:0] blink_cnt_q,   blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;   // 1 = visible half
   logic [2:0]       bright_q,      bright_d;
   logic [7:0]       seg_q,         seg_d;
   logic [3:0]       an_q,          an_d;
   logic             frame_start_q, frame_start_d;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic              slot_wrap;
   logic              blink_wrap;
   logic              slot_start;
   logic [2:0]        bright_eff;
   logic [3:0]        bright_p1;
   logic [PROD_W-1:0] on_prod;
   logic [LEN_W-1:0]  on_len;
   logic [LEN_W:0]    on_end;
   logic [LEN_W:0]    slot_pos;
   phase_e            phase;
   logic [7:0]        dig_sel;
   logic              blanked;

   // Slot counter, digit index and blink timebase.
   always_comb begin
      slot_wrap     = (slot_cnt_q == SLOT_LAST);
      slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
      idx_d         = slot_wrap ? idx_q + 2'd1 : idx_q;

      blink_wrap    = (blink_cnt_q == BLINK_LAST);
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLK_W'(1);
      blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
   end

   // Slot-start latch and ON-window length.
   // In the first cycle of a slot the live bright input is used directly,
   // so the window is correct even when GUARD is 0. That same value is
   // captured into bright_q for the rest of the slot.
   always_comb begin
      slot_start = (slot_cnt_q == '0);
      bright_eff = slot_start ? bright : bright_q;
      bright_d   = bright_eff;
      bright_p1  = {1'b0, bright_eff} + 4'd1;
      on_prod    = SPAN * PROD_W'(bright_p1);
      on_len     = LEN_W'(on_prod >> 3);
      on_end     = GUARD_W + {1'b0, on_len};
   end

   // Phase decode. Widen slot_cnt so the comparison against GUARD+on_len
   // cannot overflow.
   always_comb begin
      slot_pos = (LEN_W + 1)'(slot_cnt_q);
      if (slot_pos < GUARD_W) begin
         phase = PH_GUARD;
      end else if (slot_pos < on_end) begin
         phase = PH_ON;
      end else begin
         phase = PH_DIM;
      end
   end

   // Digit select and blink blanking.
   always_comb begin
      case (idx_q)
         2'd0:    dig_sel = dig0;
         2'd1:    dig_sel = dig1;
         2'd2:    dig_sel = dig2;
         default: dig_sel = dig3;
      endcase
      blanked = blink_en && blink_mask[idx_q] && !blink_phase_q;
   end

   // Registered output stage. Outputs are blank by default and driven only
   // during ON, so at most one anode can ever be low.
   always_comb begin
      seg_d         = 8'hFF;
      an_d          = 4'b1111;
      frame_start_d = slot_start && (idx_q == 2'd0);
      if (phase == PH_ON) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = blanked ? 8'hFF : dig_sel;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q    <= '0;
         idx_q         <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         bright_q      <= 3'd0;
         seg_q         <= 8'hFF;
         an_q          <= 4'b1111;
         frame_start_q <= 1'b0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         bright_q      <= bright_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Drives display_scan_ctrl with SCAN_DIV=16, GUARD=2, BLINK_DIV=64.
//
// For every clock edge, the driver computes the expected {frame_start, an, seg}
// from the absolute cycle number since reset release and pushes it into a
// queue. A monitor process pops one entry after each rising edge and compares
// it with the DUT outputs. The monitor also checks that an is never two-hot.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

   localparam int SD = 16;
   localparam int GD = 2;
   localparam int BD = 64;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dig [4];
   logic       blink_en;
   logic [3:0] blink_mask;
   logic [2:0] bright;
   logic [7:0] seg;
   logic [3:0] an;
   logic       frame_start;

   always #5 clk = ~clk;

   display_scan_ctrl #(
      .SCAN_DIV  (SD),
      .GUARD     (GD),
      .BLINK_DIV (BD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dig0        (dig[0]),
      .dig1        (dig[1]),
      .dig2        (dig[2]),
      .dig3        (dig[3]),
      .blink_en    (blink_en),
      .blink_mask  (blink_mask),
      .bright      (bright),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [12:0] exp_q[$];
   logic [12:0] exp_v;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          t        = 0;   // cycles since reset release (model time)
   int          slot_b   = 0;   // bright seen at the start of the current slot

   // Reference model: expected outputs after the edge that samples cycle tt.
   function automatic logic [12:0] ref_out(input int tt, input int b);
      int         sc;
      int         id;
      int         on;
      logic       visible;
      logic [3:0] a;
      logic [7:0] s;
      sc      = tt % SD;
      id      = (tt / SD) % 4;
      on      = ((SD - GD) * (b + 1)) / 8;
      visible = ((tt / BD) % 2) == 0;
      a       = 4'b1111;
      s       = 8'hFF;
      if (sc >= GD && sc < GD + on) begin
         a = ~(4'b0001 << id);
         s = (blink_en && blink_mask[id] && !visible) ? 8'hFF : dig[id];
      end
      return {(sc == 0 && id == 0), a, s};
   endfunction

   // ---------------------------------------------------------------------------
   // Driver: apply rst for the coming edge, push the expectation, then move to
   // the next falling edge.
   // ---------------------------------------------------------------------------
   task automatic step(input logic r);
      rst = r;
      if (r) begin
         exp_q.push_back({1'b0, 4'b1111, 8'hFF});
         t = 0;
      end else begin
         if (t % SD == 0) slot_b = int'(bright);
         exp_q.push_back(ref_out(t, slot_b));
         t++;
      end
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({frame_start, an, seg} !== exp_v) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d got fs=%0b an=%b seg=%h, expected fs=%0b an=%b seg=%h",
                        cyc, frame_start, an, seg, exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
            n_checks++;
            if ($countones(~an) > 1) begin
               n_fail++;
               $display("FAIL an_two_hot cyc=%0d got an=%b, expected at most one low bit", cyc, an);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      dig[0]     = 8'hC0;
      dig[1]     = 8'hF9;
      dig[2]     = 8'hA4;
      dig[3]     = 8'hB0;
      blink_en   = 1'b0;
      blink_mask = 4'b0000;
      bright     = 3'd7;

      // Reset, then full brightness for two frames.
      repeat (3) step(1'b1);
      repeat (128) step(1'b0);

      // Reduced brightness.
      bright = 3'd3;
      repeat (64) step(1'b0);
      bright = 3'd0;
      repeat (64) step(1'b0);

      // Brightness drops mid-slot; it only affects the next slot.
      bright = 3'd7;
      while (t % SD != 5) step(1'b0);
      bright = 3'd0;
      repeat (40) step(1'b0);

      // Blink digit 2.
      bright     = 3'd7;
      blink_en   = 1'b1;
      blink_mask = 4'b0100;
      repeat (300) step(1'b0);

      // Randomized run.
      repeat (2000) begin
         if ($urandom_range(0, 15) == 0) bright = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) blink_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) dig[$urandom_range(0, 3)] = 8'($urandom_range(0, 255));
         step(1'b0);
      end

      // Reset mid-slot at idx 2, slot_cnt 9, then restart.
      dig[0]   = 8'hC0;
      dig[1]   = 8'hF9;
      dig[2]   = 8'hA4;
      dig[3]   = 8'hB0;
      bright   = 3'd7;
      blink_en = 1'b0;
      while (!(((t / SD) % 4) == 2 && (t % SD) == 9)) step(1'b0);
      step(1'b1);
      repeat (80) step(1'b0);

      // Let the monitor consume the last expectation.
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending entries, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
